// File: rtl/i2s_tx_scheduler.sv
// I2S transmit scheduler: stereo-pair FIFO, bclk/lr_clk generation from clk,
// and MSB-first serialisation with the one-bit I2S delay after each lr edge.
module i2s_tx_scheduler #(
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned BCLK_DIV   = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [2*SAMPLE_W-1:0]         in_data,
  output logic                          in_ready,
  output logic                          bclk,
  output logic                          lr_clk,
  output logic                          serial,
  output logic                          rpi_interrupt,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned P_W   = $clog2(BCLK_DIV);
  localparam int unsigned B_W   = $clog2(2 * SLOT_W);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PAIR_W = 2 * SAMPLE_W;

  logic [PAIR_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [P_W-1:0]      p_q, p_d;
  logic [B_W-1:0]      b_q, b_d;
  logic [SAMPLE_W-1:0] shl_q, shl_d;
  logic [SAMPLE_W-1:0] shr_q, shr_d;
  logic                bclk_q, bclk_d;
  logic                lr_q, lr_d;
  logic                serial_q, serial_d;
  logic                irq_q, irq_d;
  logic                underrun_q, underrun_d;

  logic push, pop, bit_start, frame_start;

  // Readiness looks only at the registered level, so a full FIFO refuses even in a pop cycle.
  assign in_ready = !rst && (level_q < LVL_W'(FIFO_DEPTH));

  always_comb begin
    push        = in_valid && in_ready;
    bit_start   = enable && (p_q == '0);
    frame_start = bit_start && (b_q == '0);
    pop         = frame_start && (level_q != '0);

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q;
    p_d        = '0;
    b_d        = '0;
    shl_d      = shl_q;
    shr_d      = shr_q;
    bclk_d     = 1'b0;
    lr_d       = 1'b0;
    serial_d   = 1'b0;
    underrun_d = 1'b0;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (enable) begin
      p_d        = (p_q == P_W'(BCLK_DIV - 1)) ? '0 : p_q + P_W'(1);
      b_d        = b_q;
      bclk_d     = (p_q >= P_W'(BCLK_DIV / 2));
      lr_d       = lr_q;
      serial_d   = serial_q;
      underrun_d = underrun_q;

      if (bit_start) begin
        b_d  = (b_q == B_W'(2 * SLOT_W - 1)) ? '0 : b_q + B_W'(1);
        lr_d = (b_q >= B_W'(SLOT_W));
        if ((b_q >= B_W'(1)) && (b_q <= B_W'(SAMPLE_W))) begin
          serial_d = shl_q[SAMPLE_W-1];
          shl_d    = shl_q << 1;
        end else if ((b_q >= B_W'(SLOT_W + 1)) && (b_q <= B_W'(SLOT_W + SAMPLE_W))) begin
          serial_d = shr_q[SAMPLE_W-1];
          shr_d    = shr_q << 1;
        end else begin
          serial_d = 1'b0;
        end
      end

      // Frame start loads the next pair, or silence plus a sticky underrun flag.
      if (frame_start) begin
        if (level_q != '0) begin
          {shl_d, shr_d} = mem_q[rd_ptr_q];
        end else begin
          shl_d      = '0;
          shr_d      = '0;
          underrun_d = 1'b1;
        end
      end
    end

    irq_d = enable && (level_d <= LVL_W'(LOW_WATER));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      p_q        <= '0;
      b_q        <= '0;
      shl_q      <= '0;
      shr_q      <= '0;
      bclk_q     <= 1'b0;
      lr_q       <= 1'b0;
      serial_q   <= 1'b0;
      irq_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      p_q        <= p_d;
      b_q        <= b_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      bclk_q     <= bclk_d;
      lr_q       <= lr_d;
      serial_q   <= serial_d;
      irq_q      <= irq_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign bclk          = bclk_q;
  assign lr_clk        = lr_q;
  assign serial        = serial_q;
  assign rpi_interrupt = irq_q;
  assign underrun      = underrun_q;
  assign level         = level_q;

endmodule
